// File: rtl/cntr8_ctrl.sv
// Sequential controller for the 8-bit counter datapath: registered state code,
// registered count and a one-cycle wrap pulse, all updated on the rising edge.
module cntr8_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic             inc,
  input  logic [WIDTH-1:0] d_in,
  output logic [2:0]       state,
  output logic [WIDTH-1:0] d_out,
  output logic             wrap
);

  localparam logic [2:0] IDLE_STATE = 3'b000;
  localparam logic [2:0] LOAD_STATE = 3'b001;
  localparam logic [2:0] INC_STATE  = 3'b010;
  localparam logic [2:0] INC2_STATE = 3'b011;
  localparam logic [2:0] DEC_STATE  = 3'b100;
  localparam logic [2:0] DEC2_STATE = 3'b101;

  localparam logic [WIDTH:0] STEP1 = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] STEP2 = (WIDTH+1)'(2);

  logic [2:0]       next_state;
  logic [WIDTH-1:0] next_count;
  logic             next_wrap;
  logic             state_illegal;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   dn_diff;
  logic [WIDTH:0]   step_amt;

  assign state_illegal = (state == 3'b110) || (state == 3'b111);

  // Direction-dependent successor state while counting.
  always_comb begin
    next_state = state;
    if (state_illegal) begin
      next_state = IDLE_STATE;
    end else if (clr) begin
      next_state = IDLE_STATE;
    end else if (load) begin
      next_state = LOAD_STATE;
    end else if (en) begin
      if (inc) begin
        next_state = (state == INC_STATE) ? INC2_STATE : INC_STATE;
      end else begin
        next_state = (state == DEC_STATE) ? DEC2_STATE : DEC_STATE;
      end
    end
  end

  // Step size follows the entered state; the extra MSB carries carry/borrow.
  always_comb begin
    step_amt = STEP1;
    if ((next_state == INC2_STATE) || (next_state == DEC2_STATE)) begin
      step_amt = STEP2;
    end
    up_sum  = {1'b0, d_out} + step_amt;
    dn_diff = {1'b0, d_out} - step_amt;
  end

  always_comb begin
    next_count = d_out;
    next_wrap  = 1'b0;
    if (state_illegal || clr) begin
      next_count = '0;
    end else if (load) begin
      next_count = d_in;
    end else if (en) begin
      if (inc) begin
        next_count = up_sum[WIDTH-1:0];
        next_wrap  = up_sum[WIDTH];
      end else begin
        next_count = dn_diff[WIDTH-1:0];
        next_wrap  = dn_diff[WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE_STATE;
      d_out <= '0;
      wrap  <= 1'b0;
    end else begin
      state <= next_state;
      d_out <= next_count;
      wrap  <= next_wrap;
    end
  end

endmodule

// File: tb/tb_cntr8_ctrl.sv
// Self-checking bench for cntr8_ctrl: directed scenarios with literal expectations
// plus randomized commands checked against an arithmetic reference model.
module tb_cntr8_ctrl;

  localparam int W   = 8;
  localparam int MOD = 1 << W;

  logic         clk;
  logic         reset_n;
  logic         clr;
  logic         load;
  logic         en;
  logic         inc;
  logic [W-1:0] d_in;
  logic [2:0]   state;
  logic [W-1:0] d_out;
  logic         wrap;

  int errors;
  int checks;

  // Reference model: state code, count value, wrap flag.
  int m_state;
  int m_cnt;
  bit m_wrap;

  cntr8_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .load    (load),
    .en      (en),
    .inc     (inc),
    .d_in    (d_in),
    .state   (state),
    .d_out   (d_out),
    .wrap    (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 0;
    m_cnt   = 0;
    m_wrap  = 1'b0;
  endtask

  // Applies one rising edge worth of command rules to the model.
  task automatic model_update();
    int k;
    int tmp;
    m_wrap = 1'b0;
    if (clr) begin
      m_state = 0;
      m_cnt   = 0;
    end else if (load) begin
      m_state = 1;
      m_cnt   = int'(d_in);
    end else if (en && inc) begin
      m_state = (m_state == 2) ? 3 : 2;
      k = (m_state == 3) ? 2 : 1;
      tmp = m_cnt + k;
      m_wrap = (tmp >= MOD);
      m_cnt = tmp % MOD;
    end else if (en) begin
      m_state = (m_state == 4) ? 5 : 4;
      k = (m_state == 5) ? 2 : 1;
      tmp = m_cnt - k;
      m_wrap = (tmp < 0);
      m_cnt = (tmp + MOD) % MOD;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic drive(input bit c, input bit l, input bit e, input bit i, input logic [W-1:0] d);
    clr = c; load = l; en = e; inc = i; d_in = d;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 8'h00);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (state !== 3'b000 || d_out !== 8'h00 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial: state=%b d_out=%h wrap=%b, required 000/00/0", state, d_out, wrap);
    end
    reset_n = 1'b1;
    model_reset();
    drive(0, 1, 0, 0, 8'h40); tick();
    drive(0, 0, 1, 1, 8'h00); tick(); tick(); tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (state !== 3'b000 || d_out !== 8'h00 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: state=%b d_out=%h wrap=%b, required 000/00/0", state, d_out, wrap);
    end
    @(posedge clk);
    #1;
    checks++;
    if (state !== 3'b000 || d_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_held: state=%b d_out=%h, required 000/00", state, d_out);
    end
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    model_reset();
    drive(0, 1, 0, 0, 8'h5A); tick();
    checks++;
    if (state !== 3'b001 || d_out !== 8'h5A || wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_load: state=%b d_out=%h wrap=%b, required 001/5a/0", state, d_out, wrap);
    end
  endtask

  task automatic test_up_wrap();
    logic [2:0] es [3];
    logic [7:0] ed [3];
    logic       ew [3];
    es = '{3'b010, 3'b011, 3'b010};
    ed = '{8'hFF, 8'h01, 8'h02};
    ew = '{1'b0, 1'b1, 1'b0};
    drive(0, 1, 0, 0, 8'hFE); tick();
    drive(0, 0, 1, 1, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (state !== es[i] || d_out !== ed[i] || wrap !== ew[i]) begin
        errors++;
        $display("FAIL up_wrap[%0d]: state=%b d_out=%h wrap=%b, required %b/%h/%b",
                 i, state, d_out, wrap, es[i], ed[i], ew[i]);
      end
    end
  endtask

  task automatic test_down_borrow();
    logic [2:0] es [3];
    logic [7:0] ed [3];
    logic       ew [3];
    es = '{3'b100, 3'b101, 3'b100};
    ed = '{8'h01, 8'hFF, 8'hFE};
    ew = '{1'b0, 1'b1, 1'b0};
    drive(0, 0, 1, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (state !== es[i] || d_out !== ed[i] || wrap !== ew[i]) begin
        errors++;
        $display("FAIL down_borrow[%0d]: state=%b d_out=%h wrap=%b, required %b/%h/%b",
                 i, state, d_out, wrap, es[i], ed[i], ew[i]);
      end
    end
  endtask

  task automatic test_hold();
    drive(0, 1, 0, 0, 8'h13); tick();
    drive(0, 0, 1, 0, 8'h00); tick(); tick();
    checks++;
    if (state !== 3'b101 || d_out !== 8'h10) begin
      errors++;
      $display("FAIL hold_setup: state=%b d_out=%h, required 101/10", state, d_out);
    end
    drive(0, 0, 0, 1, 8'hAA);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (state !== 3'b101 || d_out !== 8'h10 || wrap !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: state=%b d_out=%h wrap=%b, required 101/10/0", i, state, d_out, wrap);
      end
    end
  endtask

  task automatic test_priority();
    drive(1, 1, 1, 1, 8'h77); tick();
    checks++;
    if (state !== 3'b000 || d_out !== 8'h00 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL prio_clr: state=%b d_out=%h wrap=%b, required 000/00/0", state, d_out, wrap);
    end
    drive(0, 1, 1, 1, 8'h33); tick();
    checks++;
    if (state !== 3'b001 || d_out !== 8'h33 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL prio_load: state=%b d_out=%h wrap=%b, required 001/33/0", state, d_out, wrap);
    end
    drive(0, 1, 1, 0, 8'h00); tick();
    checks++;
    if (state !== 3'b001 || d_out !== 8'h00 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL prio_load_zero: state=%b d_out=%h wrap=%b, required 001/00/0", state, d_out, wrap);
    end
  endtask

  task automatic test_dir_flip();
    drive(0, 1, 0, 0, 8'h1D); tick();
    drive(0, 0, 1, 1, 8'h00); tick(); tick();
    checks++;
    if (state !== 3'b011 || d_out !== 8'h20) begin
      errors++;
      $display("FAIL flip_setup: state=%b d_out=%h, required 011/20", state, d_out);
    end
    drive(0, 0, 1, 0, 8'h00); tick();
    checks++;
    if (state !== 3'b100 || d_out !== 8'h1F || wrap !== 1'b0) begin
      errors++;
      $display("FAIL flip_first: state=%b d_out=%h wrap=%b, required 100/1f/0", state, d_out, wrap);
    end
    tick();
    checks++;
    if (state !== 3'b101 || d_out !== 8'h1D || wrap !== 1'b0) begin
      errors++;
      $display("FAIL flip_second: state=%b d_out=%h wrap=%b, required 101/1d/0", state, d_out, wrap);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, W'($urandom));
      tick();
      checks++;
      if (state !== 3'(m_state) || d_out !== W'(m_cnt) || wrap !== m_wrap) begin
        errors++;
        $display("FAIL random[%0d]: state=%b d_out=%h wrap=%b, required %b/%h/%b",
                 i, state, d_out, wrap, 3'(m_state), W'(m_cnt), m_wrap);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 8'h00);
    model_reset();
    test_reset();
    test_up_wrap();
    test_down_borrow();
    test_hold();
    test_priority();
    test_dir_flip();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
